// File: rtl/alm_ctrl_pkg.sv
// Shared encodings for the ALM register-bank controller.
// The VERIFY state exists only when READBACK_CHECK_EN is defined.
package alm_ctrl_pkg;

    localparam int CMD_OP_W = 2;

    localparam logic [CMD_OP_W-1:0] OP_LOAD  = 2'b00;
    localparam logic [CMD_OP_W-1:0] OP_CLEAR = 2'b01;
    localparam logic [CMD_OP_W-1:0] OP_HOLD  = 2'b10;
    localparam logic [CMD_OP_W-1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRIVE,
        ST_HOLD,
        ST_SAMPLE,
        ST_RESP
`ifdef READBACK_CHECK_EN
        ,
        ST_VERIFY
`endif
    } state_t;

endpackage

// File: rtl/alm_hold_timer.sv
// Loadable down-counter for HOLD commands; done is high while the count sits at 1,
// i.e. during the last hold cycle.
module alm_hold_timer #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    output logic              done
);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - HOLD_W'(1);
        end
    end

    assign done = (count == HOLD_W'(1));

endmodule

// File: rtl/alm_reg_bank_ctrl.sv
// Command-driven sequencer for an ALM-style register bank with readback channel.
// Optional READBACK_CHECK_EN adds a VERIFY cycle after LOAD and a sticky mismatch_err.
//
// state   | meaning
// INIT    | one clk_en+clear_sync pulse to clear the bank after reset
// IDLE    | cmd_ready high, waiting for a command
// DRIVE   | one-cycle LOAD or CLEAR strobe on the bank
// HOLD    | clk_en low for N cycles
// SAMPLE  | bank output captured into rsp_data
// RESP    | rsp_valid high until the consumer accepts
// VERIFY  | compare bank output with the loaded value (macro only)
module alm_reg_bank_ctrl
    import alm_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CMD_OP_W-1:0] cmd_op,
    input  logic [WIDTH-1:0]    cmd_data,
    output logic [WIDTH-1:0]    bank_data_in,
    output logic                bank_clk_en,
    output logic                bank_clear_sync,
    input  logic [WIDTH-1:0]    bank_data_out_reg,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic                busy,
    output logic                mismatch_err
);

    state_t           state, state_nx;
    logic             clk_en_nx, clear_nx, timer_load, hold_done;
    logic [WIDTH-1:0] data_in_nx, rsp_data_nx;

`ifdef READBACK_CHECK_EN
    logic             load_q;
    logic [WIDTH-1:0] load_val_q;
`endif

    alm_hold_timer #(.HOLD_W(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (cmd_data[HOLD_W-1:0]),
        .done     (hold_done)
    );

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        state_nx    = state;
        clk_en_nx   = 1'b0;
        clear_nx    = 1'b0;
        data_in_nx  = bank_data_in;
        rsp_data_nx = rsp_data;
        timer_load  = 1'b0;
        case (state)
            ST_INIT: begin
                if (!bank_clear_sync) begin
                    clk_en_nx = 1'b1;
                    clear_nx  = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_op == OP_LOAD) begin
                        state_nx   = ST_DRIVE;
                        clk_en_nx  = 1'b1;
                        data_in_nx = cmd_data;
                    end else if (cmd_op == OP_CLEAR) begin
                        state_nx  = ST_DRIVE;
                        clk_en_nx = 1'b1;
                        clear_nx  = 1'b1;
                    end else if (cmd_op == OP_HOLD) begin
                        timer_load = 1'b1;
                        if (cmd_data[HOLD_W-1:0] != '0) state_nx = ST_HOLD;
                    end else begin
                        state_nx = ST_SAMPLE;
                    end
                end
            end
            ST_DRIVE: begin
`ifdef READBACK_CHECK_EN
                state_nx = load_q ? ST_VERIFY : ST_IDLE;
`else
                state_nx = ST_IDLE;
`endif
            end
            ST_HOLD: begin
                if (hold_done) state_nx = ST_IDLE;
            end
            ST_SAMPLE: begin
                state_nx    = ST_RESP;
                rsp_data_nx = bank_data_out_reg;
            end
            ST_RESP: begin
                if (rsp_ready) state_nx = ST_IDLE;
            end
`ifdef READBACK_CHECK_EN
            ST_VERIFY: state_nx = ST_IDLE;
`endif
            default: state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_INIT;
            cmd_ready       <= 1'b0;
            busy            <= 1'b1;
            bank_clk_en     <= 1'b0;
            bank_clear_sync <= 1'b0;
            bank_data_in    <= '0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
        end else begin
            state           <= state_nx;
            cmd_ready       <= (state_nx == ST_IDLE);
            busy            <= (state_nx != ST_IDLE);
            bank_clk_en     <= clk_en_nx;
            bank_clear_sync <= clear_nx;
            bank_data_in    <= data_in_nx;
            rsp_valid       <= (state_nx == ST_RESP);
            rsp_data        <= rsp_data_nx;
        end
    end

`ifdef READBACK_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            load_q       <= 1'b0;
            load_val_q   <= '0;
            mismatch_err <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                load_q     <= (cmd_op == OP_LOAD);
                load_val_q <= cmd_data;
            end
            if (state == ST_VERIFY && bank_data_out_reg != load_val_q) mismatch_err <= 1'b1;
        end
    end
`else
    assign mismatch_err = 1'b0;
`endif

endmodule

// File: tb/tb_alm_reg_bank_ctrl.sv
// Directed bench for alm_reg_bank_ctrl with a behavioural ALM register bank and a readback scoreboard.
module tb_alm_reg_bank_ctrl;
    import alm_ctrl_pkg::*;

    localparam int WIDTH  = 8;
    localparam int HOLD_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [WIDTH-1:0] bank_data_in;
    logic             bank_clk_en;
    logic             bank_clear_sync;
    logic [WIDTH-1:0] bank_q = 8'h77;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic             mismatch_err;

    int               total = 0;
    int               bad = 0;
    logic [WIDTH-1:0] exp_bank = '0;
    logic [WIDTH-1:0] exp_din = '0;
    logic [WIDTH-1:0] exp_q[$];
    logic             corrupt = 1'b0;

    alm_reg_bank_ctrl #(.WIDTH(WIDTH), .HOLD_W(HOLD_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_data          (cmd_data),
        .bank_data_in      (bank_data_in),
        .bank_clk_en       (bank_clk_en),
        .bank_clear_sync   (bank_clear_sync),
        .bank_data_out_reg (bank_q),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .busy              (busy),
        .mismatch_err      (mismatch_err)
    );

    always #5 clk = ~clk;

    // Bank model; corrupt makes it capture the inverse of data_in.
    always @(posedge clk) begin
        if (bank_clk_en) bank_q <= bank_clear_sync ? '0 : (corrupt ? ~bank_data_in : bank_data_in);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk1(tag, cmd_ready, 1'b1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] data);
        wait_ready("issue_ready");
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic reset_seq();
        reset = 1'b1;
        @(negedge clk);
        chk1("rst_ready", cmd_ready, 1'b0);
        chk1("rst_busy", busy, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_clk_en", bank_clk_en, 1'b0);
        chk1("rst_clear", bank_clear_sync, 1'b0);
        chk8("rst_din", bank_data_in, 8'h00);
        chk8("rst_rsp_data", rsp_data, 8'h00);
        chk1("rst_mismatch", mismatch_err, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk1("init_clk_en", bank_clk_en, 1'b1);
        chk1("init_clear", bank_clear_sync, 1'b1);
        chk1("init_ready", cmd_ready, 1'b0);
        @(negedge clk);
        chk1("init_clk_en_off", bank_clk_en, 1'b0);
        chk1("init_clear_off", bank_clear_sync, 1'b0);
        chk1("init_idle_ready", cmd_ready, 1'b1);
        chk1("init_idle_busy", busy, 1'b0);
        chk8("init_bank", bank_q, 8'h00);
        exp_bank = '0;
        exp_din  = '0;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        issue(OP_LOAD, v);
        chk1("load_clk_en", bank_clk_en, 1'b1);
        chk1("load_clear", bank_clear_sync, 1'b0);
        chk8("load_din", bank_data_in, v);
        chk1("load_busy", busy, 1'b1);
        chk1("load_ready", cmd_ready, 1'b0);
        exp_bank = corrupt ? ~v : v;
        exp_din  = v;
        @(negedge clk);
        chk1("load_clk_en_off", bank_clk_en, 1'b0);
        chk8("load_bank", bank_q, exp_bank);
`ifdef READBACK_CHECK_EN
        chk1("load_verify_ready", cmd_ready, 1'b0);
        @(negedge clk);
`endif
        chk1("load_done_ready", cmd_ready, 1'b1);
    endtask

    task automatic do_clear();
        issue(OP_CLEAR, 8'hC3);
        chk1("clear_clk_en", bank_clk_en, 1'b1);
        chk1("clear_sync", bank_clear_sync, 1'b1);
        chk8("clear_din_kept", bank_data_in, exp_din);
        exp_bank = '0;
        @(negedge clk);
        chk1("clear_done_ready", cmd_ready, 1'b1);
        chk8("clear_bank", bank_q, 8'h00);
    endtask

    task automatic do_hold(input int n);
        issue(OP_HOLD, 8'hF0 | 8'(n));
        for (int i = 0; i < n; i++) begin
            chk1("hold_busy", busy, 1'b1);
            chk1("hold_clk_en", bank_clk_en, 1'b0);
            chk1("hold_ready", cmd_ready, 1'b0);
            @(negedge clk);
        end
        chk1("hold_done_ready", cmd_ready, 1'b1);
        chk1("hold_done_busy", busy, 1'b0);
    endtask

    task automatic do_read(input int stall);
        exp_q.push_back(exp_bank);
        issue(OP_READ, 8'h00);
        chk1("read_sample_valid", rsp_valid, 1'b0);
        @(negedge clk);
        chk1("read_valid", rsp_valid, 1'b1);
        for (int i = 0; i < stall; i++) begin
            chk1("read_stall_valid", rsp_valid, 1'b1);
            chk8("read_stall_data", rsp_data, exp_q[0]);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk1("read_accept_valid", rsp_valid, 1'b1);
        chk8("read_data", rsp_data, exp_q.pop_front());
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("read_valid_off", rsp_valid, 1'b0);
        chk1("read_idle_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        reset_seq();
        do_read(0);

        do_load(8'hA5);
        do_read(0);

        do_load(8'h3C);
        do_read(5);

        do_load(8'hFF);
        do_hold(3);
        chk8("hold_bank_kept", bank_q, 8'hFF);
        do_hold(0);
        do_hold(15);
        do_read(1);

        do_load(8'h5A);
        do_clear();
        do_read(2);
        chk8("din_after_clear", bank_data_in, 8'h5A);

        // cmd_valid held high across a LOAD: the following CLEAR waits for IDLE.
        wait_ready("b2b_ready");
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 8'h81;
        @(negedge clk);
        cmd_op = OP_CLEAR;
        chk1("b2b_load_clear", bank_clear_sync, 1'b0);
        chk8("b2b_load_din", bank_data_in, 8'h81);
        @(negedge clk);
        chk8("b2b_bank_loaded", bank_q, 8'h81);
        wait_ready("b2b_idle");
        @(negedge clk);
        cmd_valid = 1'b0;
        chk1("b2b_clear_en", bank_clk_en, 1'b1);
        chk1("b2b_clear_sync", bank_clear_sync, 1'b1);
        @(negedge clk);
        chk8("b2b_bank_cleared", bank_q, 8'h00);
        exp_bank = '0;
        exp_din  = 8'h81;

        // Reset while a response is pending.
        do_load(8'h3C);
        issue(OP_READ, 8'h00);
        @(negedge clk);
        chk1("abort_resp_valid", rsp_valid, 1'b1);
        chk8("abort_resp_data", rsp_data, 8'h3C);
        reset_seq();
        do_read(0);

`ifdef READBACK_CHECK_EN
        corrupt = 1'b1;
        do_load(8'h11);
        chk1("mismatch_set", mismatch_err, 1'b1);
        corrupt = 1'b0;
        do_load(8'h22);
        chk1("mismatch_sticky", mismatch_err, 1'b1);
        reset_seq();
        do_load(8'h44);
        chk1("mismatch_clean_load", mismatch_err, 1'b0);
`else
        do_load(8'h44);
        chk1("mismatch_tied_low", mismatch_err, 1'b0);
`endif
        do_read(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
